// File: rtl/input_cond_pkg.sv
// Shared types and default constants for the board input conditioning front end.
package input_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_SIM   = 16;
    localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;
    localparam int SYNC_STAGES_DEF       = 2;

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: synchronizer chain, debounce FSM with its stability counter,
// and a registered level plus a one-cycle rise flag marking the accepted press.
module button_debounce
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    btn_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
        end
    end

    // Any sample against the pending direction drops the wait; the level only
    // moves once the counter has seen DEBOUNCE_CYCLES further agreeing samples.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= HELD;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!w_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_s) begin
                        r_state <= HELD;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= IDLE;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end for the multiplier: debounced Run/RLC levels, a single Run
// press pulse blocked while Reset_Load_Clear is active, and a synchronized switch bus.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run_btn_i,
    input  logic       RLC_btn_i,
    input  logic [7:0] SW_i,
    output logic       Run_o,
    output logic       Run_pulse_o,
    output logic       Reset_Load_Clear_o,
    output logic [7:0] SW_o
);

    logic [SYNC_STAGES-1:0][7:0] r_sw_sync;
    logic                        w_run_level;
    logic                        w_run_rise;
    logic                        w_rlc_level;
    logic                        w_rlc_rise;
    logic                        w_run_blocked;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sw_sync <= '0;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], SW_i};
        end
    end

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_run_debounce (
        .i_clk    (Clk),
        .i_reset_n(Reset_n),
        .i_btn    (Run_btn_i),
        .o_level  (w_run_level),
        .o_rise   (w_run_rise)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rlc_debounce (
        .i_clk    (Clk),
        .i_reset_n(Reset_n),
        .i_btn    (RLC_btn_i),
        .o_level  (w_rlc_level),
        .o_rise   (w_rlc_rise)
    );

    // An RLC press accepted on the same edge as Run blocks the pulse too; a
    // blocked pulse is dropped rather than held for later.
    assign w_run_blocked      = w_rlc_level | w_rlc_rise;
    assign Run_pulse_o        = w_run_rise & ~w_run_blocked;
    assign Run_o              = w_run_level;
    assign Reset_Load_Clear_o = w_rlc_level;
    assign SW_o               = r_sw_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus a random soak,
// all compared against a run-length reference model of the debounce rules.
module tb_input_conditioner;

    localparam int D = 16;
    localparam int S = 2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Run_btn_i = 1'b0;
    logic       RLC_btn_i = 1'b0;
    logic [7:0] SW_i = 8'h00;
    logic       Run_o;
    logic       Run_pulse_o;
    logic       Reset_Load_Clear_o;
    logic [7:0] SW_o;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: delay lines stand in for the synchronizers, and a button
    // level flips once D+1 consecutive synchronized samples disagree with it.
    bit         runDl[$];
    bit         rlcDl[$];
    logic [7:0] swDl[$];
    bit         mRun, mRlc, mPulse;
    int         runCnt, rlcCnt;
    logic [7:0] mSw;

    always #5 Clk = ~Clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .Run_btn_i         (Run_btn_i),
        .RLC_btn_i         (RLC_btn_i),
        .SW_i              (SW_i),
        .Run_o             (Run_o),
        .Run_pulse_o       (Run_pulse_o),
        .Reset_Load_Clear_o(Reset_Load_Clear_o),
        .SW_o              (SW_o)
    );

    task automatic modelClear();
        runDl = {};
        rlcDl = {};
        swDl  = {};
        for (int k = 0; k < S; k++) begin
            runDl.push_back(1'b0);
            rlcDl.push_back(1'b0);
            swDl.push_back(8'h00);
        end
        mRun = 1'b0; mRlc = 1'b0; mPulse = 1'b0;
        runCnt = 0; rlcCnt = 0;
        mSw = 8'h00;
    endtask

    // Advances the model by one rising edge using the inputs currently driven.
    task automatic modelStep();
        bit sRun, sRlc, prevRun;
        if (!Reset_n) begin
            modelClear();
        end else begin
            sRun = runDl.pop_front();
            sRlc = rlcDl.pop_front();
            void'(swDl.pop_front());
            runDl.push_back(Run_btn_i);
            rlcDl.push_back(RLC_btn_i);
            swDl.push_back(SW_i);
            mSw = swDl[0];
            prevRun = mRun;
            runCnt = (sRun != mRun) ? runCnt + 1 : 0;
            if (runCnt == D + 1) begin
                mRun = ~mRun;
                runCnt = 0;
            end
            rlcCnt = (sRlc != mRlc) ? rlcCnt + 1 : 0;
            if (rlcCnt == D + 1) begin
                mRlc = ~mRlc;
                rlcCnt = 0;
            end
            mPulse = !prevRun && mRun && !mRlc;
        end
    endtask

    // Drives inputs at a falling edge, advances the model, then waits past the rising edge.
    task automatic step(input bit run, input bit rlc, input logic [7:0] sw, input bit rstn);
        Run_btn_i = run;
        RLC_btn_i = rlc;
        SW_i      = sw;
        Reset_n   = rstn;
        modelStep();
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    function automatic logic [10:0] actVec();
        return {Run_o, Run_pulse_o, Reset_Load_Clear_o, SW_o};
    endfunction

    function automatic logic [10:0] expVec();
        return {mRun, mPulse, mRlc, mSw};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'hFF, 1'b0);
            testsRun++;
            if (actVec() !== 11'h000) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold cyc %0d: got %h want 000", i, actVec());
            end
        end
        for (int e = 1; e <= 25; e++) begin
            step(1'b1, 1'b1, 8'hFF, 1'b1);
            testsRun++;
            if (SW_o !== ((e >= 2) ? 8'hFF : 8'h00)) begin
                testsFailed++;
                $display("[TB] FAIL reset_sw_latency edge %0d: got %h want %h", e, SW_o, (e >= 2) ? 8'hFF : 8'h00);
            end
            testsRun++;
            if (Run_o !== 1'(e >= 19) || Run_pulse_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_run_latency edge %0d: got run=%b pulse=%b want run=%b pulse=0", e, Run_o, Run_pulse_o, e >= 19);
            end
            testsRun++;
            if (actVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL reset_model edge %0d: got %h want %h", e, actVec(), expVec());
            end
        end
        idle(25);
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int pulseAt = -1;
        for (int i = 0; i < 70; i++) begin
            step(i < 40, 1'b0, 8'h00, 1'b1);
            if (Run_pulse_o === 1'b1) begin
                pulses++;
                pulseAt = i;
            end
            testsRun++;
            if (Run_o !== 1'(i >= 18 && i < 58)) begin
                testsFailed++;
                $display("[TB] FAIL clean_press_level cyc %0d: got %b want %b", i, Run_o, i >= 18 && i < 58);
            end
            testsRun++;
            if (actVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL clean_press_model cyc %0d: got %h want %h", i, actVec(), expVec());
            end
        end
        testsRun++;
        if (pulses !== 1 || pulseAt !== 18) begin
            testsFailed++;
            $display("[TB] FAIL clean_press_pulse: got %0d pulses at %0d want 1 at 18", pulses, pulseAt);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int pulseAt = -1;
        for (int i = 0; i < 80; i++) begin
            step((i < 30) ? ((i / 3) % 2 == 0) : 1'b1, 1'b0, 8'h00, 1'b1);
            if (Run_pulse_o === 1'b1) begin
                pulses++;
                pulseAt = i;
            end
            testsRun++;
            if (actVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL bounce_model cyc %0d: got %h want %h", i, actVec(), expVec());
            end
        end
        testsRun++;
        if (pulses !== 1 || pulseAt !== 48) begin
            testsFailed++;
            $display("[TB] FAIL bounce_pulse: got %0d pulses at %0d want 1 at 48", pulses, pulseAt);
        end
        idle(30);
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 40; i++) begin
            step(i < 10, 1'b0, 8'h00, 1'b1);
            testsRun++;
            if (Run_o !== 1'b0 || Run_pulse_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL glitch cyc %0d: got run=%b pulse=%b want 0 0", i, Run_o, Run_pulse_o);
            end
        end
    endtask

    task automatic test_release_bounce();
        int pulses = 0;
        for (int i = 0; i < 80; i++) begin
            step(!(i >= 30 && i < 40), 1'b0, 8'h00, 1'b1);
            if (Run_pulse_o === 1'b1) pulses++;
            testsRun++;
            if (Run_o !== 1'(i >= 18)) begin
                testsFailed++;
                $display("[TB] FAIL release_bounce_level cyc %0d: got %b want %b", i, Run_o, i >= 18);
            end
        end
        testsRun++;
        if (pulses !== 1) begin
            testsFailed++;
            $display("[TB] FAIL release_bounce_pulses: got %0d want 1", pulses);
        end
        idle(30);
    endtask

    task automatic test_interlock();
        int pulses = 0;
        int pulseAt = -1;
        for (int i = 0; i < 60; i++) begin
            step(i >= 25, 1'b1, 8'h00, 1'b1);
            if (Run_pulse_o === 1'b1) pulses++;
            testsRun++;
            if (Run_o !== 1'(i >= 43) || Reset_Load_Clear_o !== 1'(i >= 18)) begin
                testsFailed++;
                $display("[TB] FAIL interlock_levels cyc %0d: got run=%b rlc=%b want run=%b rlc=%b", i, Run_o, Reset_Load_Clear_o, i >= 43, i >= 18);
            end
        end
        testsRun++;
        if (pulses !== 0) begin
            testsFailed++;
            $display("[TB] FAIL interlock_suppress: got %0d pulses want 0", pulses);
        end
        idle(30);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            if (Run_pulse_o === 1'b1) begin
                pulses++;
                pulseAt = i;
            end
        end
        testsRun++;
        if (pulses !== 1 || pulseAt !== 18) begin
            testsFailed++;
            $display("[TB] FAIL interlock_repress: got %0d pulses at %0d want 1 at 18", pulses, pulseAt);
        end
        idle(30);
    endtask

    task automatic test_switch();
        logic [7:0] drive [8];
        logic [7:0] want [8];
        drive = '{8'hC5, 8'hC5, 8'hC5, 8'hC5, 8'h07, 8'h07, 8'h07, 8'h07};
        want  = '{8'h00, 8'hC5, 8'hC5, 8'hC5, 8'hC5, 8'h07, 8'h07, 8'h07};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, drive[i], 1'b1);
            testsRun++;
            if (SW_o !== want[i]) begin
                testsFailed++;
                $display("[TB] FAIL switch_path cyc %0d: got %h want %h", i, SW_o, want[i]);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int pulseAt = -1;
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        testsRun++;
        if (Run_o !== 1'b0 || Run_pulse_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_drop: got run=%b pulse=%b want 0 0", Run_o, Run_pulse_o);
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            if (Run_pulse_o === 1'b1) begin
                pulses++;
                pulseAt = i;
            end
            testsRun++;
            if (Run_o !== 1'(i >= 18)) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_reaccept cyc %0d: got %b want %b", i, Run_o, i >= 18);
            end
        end
        testsRun++;
        if (pulses !== 1 || pulseAt !== 18) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_pulse: got %0d pulses at %0d want 1 at 18", pulses, pulseAt);
        end
        idle(30);
    endtask

    task automatic test_random();
        bit run = 1'b0;
        bit rlc = 1'b0;
        logic [7:0] sw = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) run = ~run;
            if ($urandom_range(0, 13) == 0) rlc = ~rlc;
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            step(run, rlc, sw, $urandom_range(0, 299) != 0);
            testsRun++;
            if (actVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL random_model cyc %0d: got %h want %h", i, actVec(), expVec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelClear();
        @(negedge Clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_bounce();
        test_interlock();
        test_switch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
